// File: rtl/frame_sched_pkg.sv
// frame_sched_pkg: shared state enums and bank/index helpers
// for the ping-pong frame scheduler.
package frame_sched_pkg;

  typedef enum logic [1:0] {
    W_IDLE,
    W_SETTLE,
    W_CAPTURE
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_READ,
    R_DRAIN
  } rd_state_e;

  // Default geometry: 1024-point frames, address {bank, index}.
  localparam int N_DEF    = 1024;
  localparam int AW_DEF   = $clog2(N_DEF) + 1;
  localparam int BANK_BIT = AW_DEF - 1;
  localparam int IDX_W    = AW_DEF - 1;

  // Same helpers for a non-default address width.
  function automatic int bank_bit_of(input int aw);
    return aw - 1;
  endfunction

  function automatic int idx_w_of(input int aw);
    return aw - 1;
  endfunction

endpackage

// File: rtl/frame_sched_drain_wdog.sv
// frame_sched_drain_wdog: counts cycles spent draining and
// fires on the LIMIT-th consecutive cycle.
module frame_sched_drain_wdog #(
  parameter int LIMIT = 65535
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic run_i,
  output logic fire_o
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;

  assign fire_o = run_i && (cnt_q == CW'(LIMIT - 1));

  // Count while draining; restart whenever drain ends.
  always_ff @(posedge clk_i) begin
    if (!rst_n || !run_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/frame_sched.sv
// frame_sched: ping-pong frame scheduler for the FMCW receive path.
// Optional drain watchdog is built when FRAME_SCHED_TIMEOUT_EN is defined.
module frame_sched
  import frame_sched_pkg::*;
#(
  parameter int N              = 1024,
  parameter int SETTLE         = 8,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int AW             = $clog2(N) + 1
) (
  input  logic          clk_i,
  input  logic          rst_n,
  input  logic          chirp_start_i,
  input  logic          sample_en_i,
  input  logic          rd_ce_i,
  input  logic          fft_done_i,
  output logic          wr_en_o,
  output logic [AW-1:0] wr_addr_o,
  output logic          rd_en_o,
  output logic [AW-1:0] rd_addr_o,
  output logic          fft_en_o,
  output logic [15:0]   frame_ctr_o,
  output logic [7:0]    drop_ctr_o,
  output logic          timeout_o
);

  localparam int BB = bank_bit_of(AW);
  localparam int IW = idx_w_of(AW);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [SW-1:0] LAST_SET = SW'(SETTLE - 1);

  // Writer state
  wr_state_e      wr_st_q;
  logic           wr_bank_q;
  logic [IW-1:0]  widx_q;
  logic [SW-1:0]  scnt_q;
  logic           wr_en_q;
  logic [AW-1:0]  wr_addr_q;

  // Reader state
  rd_state_e      rd_st_q;
  logic           rd_bank_q;
  logic [IW-1:0]  ridx_q;
  logic           rd_en_q;
  logic [AW-1:0]  rd_addr_q;
  logic           fft_en_q;
  logic [15:0]    frame_q;

  // Bank bookkeeping
  logic [1:0]     full_q;
  logic [1:0]     full_d;
  logic [7:0]     drop_q;
  logic [7:0]     drop_d;
  logic [8:0]     drop_sum;

  logic [1:0]     bank_ok;
  logic           rd_busy;
  logic           rd_pick;
  logic           w_fill;
  logic           w_drop;
  logic           r_drain;
  logic           r_rel;
  logic           wd_fire;
  logic           t_drop;

  assign rd_busy = (rd_st_q != R_IDLE);
  assign r_drain = (rd_st_q == R_DRAIN);

  // A bank is writable when empty and not held by the reader.
  assign bank_ok[0] = !full_q[0] && !(rd_busy && !rd_bank_q);
  assign bank_ok[1] = !full_q[1] && !(rd_busy && rd_bank_q);

  // Both full: take the bank not read last time.
  assign rd_pick = (full_q == 2'b11) ? ~rd_bank_q : full_q[1];

  assign w_fill = (wr_st_q == W_CAPTURE) && !chirp_start_i
               && sample_en_i && (widx_q == LAST_IDX);

  assign w_drop = chirp_start_i
               && ((wr_st_q != W_IDLE) || (bank_ok == 2'b00));

  assign r_rel  = r_drain && (fft_done_i || wd_fire);
  assign t_drop = r_drain && wd_fire && !fft_done_i;

  // Writer: bank choice, settle discard, capture addressing
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      wr_st_q   <= W_IDLE;
      wr_bank_q <= 1'b0;
      widx_q    <= '0;
      scnt_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      wr_en_q <= 1'b0;
      unique case (wr_st_q)
        W_IDLE: begin
          if (chirp_start_i && (bank_ok != 2'b00)) begin
            wr_bank_q <= !bank_ok[0];
            scnt_q    <= '0;
            wr_st_q   <= W_SETTLE;
          end
        end
        W_SETTLE: begin
          if (chirp_start_i) begin
            scnt_q <= '0;
          end else if (sample_en_i) begin
            if (scnt_q == LAST_SET) begin
              widx_q  <= '0;
              wr_st_q <= W_CAPTURE;
            end else begin
              scnt_q <= scnt_q + 1'b1;
            end
          end
        end
        W_CAPTURE: begin
          if (chirp_start_i) begin
            scnt_q  <= '0;
            wr_st_q <= W_SETTLE;
          end else if (sample_en_i) begin
            wr_en_q             <= 1'b1;
            wr_addr_q[BB]       <= wr_bank_q;
            wr_addr_q[IW-1:0]   <= widx_q;
            widx_q              <= widx_q + 1'b1;
            if (widx_q == LAST_IDX) begin
              wr_st_q <= W_IDLE;
            end
          end
        end
        default: wr_st_q <= W_IDLE;
      endcase
    end
  end

  // Reader: bank selection, paced reads, drain hold
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      rd_st_q   <= R_IDLE;
      rd_bank_q <= 1'b0;
      ridx_q    <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      fft_en_q  <= 1'b0;
      frame_q   <= '0;
    end else begin
      rd_en_q <= 1'b0;
      unique case (rd_st_q)
        R_IDLE: begin
          if (full_q != 2'b00) begin
            rd_bank_q <= rd_pick;
            ridx_q    <= '0;
            frame_q   <= frame_q + 16'd1;
            rd_st_q   <= R_READ;
          end
        end
        R_READ: begin
          if (rd_ce_i) begin
            rd_en_q           <= 1'b1;
            rd_addr_q[BB]     <= rd_bank_q;
            rd_addr_q[IW-1:0] <= ridx_q;
            fft_en_q          <= 1'b1;
            ridx_q            <= ridx_q + 1'b1;
            if (ridx_q == LAST_IDX) begin
              rd_st_q <= R_DRAIN;
            end
          end
        end
        R_DRAIN: begin
          if (r_rel) begin
            fft_en_q <= 1'b0;
            rd_st_q  <= R_IDLE;
          end
        end
        default: rd_st_q <= R_IDLE;
      endcase
    end
  end

  // Next full mask and saturating drop count
  always_comb begin
    full_d = full_q;
    if (w_fill) begin
      full_d[wr_bank_q] = 1'b1;
    end
    if (r_rel) begin
      full_d[rd_bank_q] = 1'b0;
    end
    drop_sum = {1'b0, drop_q} + {8'd0, w_drop} + {8'd0, t_drop};
    drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  // Bank bookkeeping registers
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      full_q <= 2'b00;
      drop_q <= '0;
    end else begin
      full_q <= full_d;
      drop_q <= drop_d;
    end
  end

`ifdef FRAME_SCHED_TIMEOUT_EN
  logic timeout_q;

  frame_sched_drain_wdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk_i  (clk_i),
    .rst_n  (rst_n),
    .run_i  (r_drain),
    .fire_o (wd_fire)
  );

  // Sticky watchdog flag
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else if (t_drop) begin
      timeout_q <= 1'b1;
    end
  end

  assign timeout_o = timeout_q;
`else
  localparam int unused_tmo = TIMEOUT_CYCLES;

  assign wd_fire   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign wr_en_o     = wr_en_q;
  assign wr_addr_o   = wr_addr_q;
  assign rd_en_o     = rd_en_q;
  assign rd_addr_o   = rd_addr_q;
  assign fft_en_o    = fft_en_q;
  assign frame_ctr_o = frame_q;
  assign drop_ctr_o  = drop_q;

endmodule

// File: tb/tb_frame_sched.sv
// tb_frame_sched: directed bench for frame_sched (N=16, SETTLE=2)
// with a frame-level reference model compared every cycle.
module tb_frame_sched;

  localparam int N   = 16;
  localparam int S   = 2;
  localparam int TMO = 100;
`ifdef FRAME_SCHED_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       chirp_start = 1'b0;
  logic       sample_en = 1'b0;
  logic       rd_ce = 1'b0;
  logic       fft_done = 1'b0;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic       rd_en;
  logic [4:0] rd_addr;
  logic       fft_en;
  logic [15:0] frame_ctr;
  logic [7:0] drop_ctr;
  logic       timeout;

  frame_sched #(
    .N              (N),
    .SETTLE         (S),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i         (clk),
    .rst_n         (rst_n),
    .chirp_start_i (chirp_start),
    .sample_en_i   (sample_en),
    .rd_ce_i       (rd_ce),
    .fft_done_i    (fft_done),
    .wr_en_o       (wr_en),
    .wr_addr_o     (wr_addr),
    .rd_en_o       (rd_en),
    .rd_addr_o     (rd_addr),
    .fft_en_o      (fft_en),
    .frame_ctr_o   (frame_ctr),
    .drop_ctr_o    (drop_ctr),
    .timeout_o     (timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: frame-level bookkeeping per clock
  int  mw = 0, mwb = 0, mset = 0, mwi = 0;
  int  mr = 0, mrb = 0, mri = 0, mdrain = 0;
  bit  mfull[2];
  bit  m_wr_en = 0, m_rd_en = 0, m_fft = 0, m_to = 0;
  int  m_wr_addr = 0, m_rd_addr = 0, m_frames = 0, m_drops = 0;
  bit  avail[2];
  bit  fill, rel;
  int  drops;

  always @(posedge clk) begin
    if (!rst_n) begin
      mw = 0; mwb = 0; mset = 0; mwi = 0;
      mr = 0; mrb = 0; mri = 0; mdrain = 0;
      mfull[0] = 0; mfull[1] = 0;
      m_wr_en = 0; m_rd_en = 0; m_fft = 0; m_to = 0;
      m_wr_addr = 0; m_rd_addr = 0; m_frames = 0; m_drops = 0;
    end else begin
      fill = 0; rel = 0; drops = 0;
      m_wr_en = 0; m_rd_en = 0;
      for (int b = 0; b < 2; b++)
        avail[b] = !mfull[b] && !(mr != 0 && mrb == b);
      if (chirp_start) begin
        if (mw == 0) begin
          if (avail[0] || avail[1]) begin
            mwb = avail[0] ? 0 : 1;
            mw = 1; mset = 0;
          end else drops++;
        end else begin
          drops++; mw = 1; mset = 0;
        end
      end else if (sample_en) begin
        if (mw == 1) begin
          mset++;
          if (mset == S) begin mw = 2; mwi = 0; end
        end else if (mw == 2) begin
          m_wr_en = 1; m_wr_addr = mwb * N + mwi; mwi++;
          if (mwi == N) begin fill = 1; mw = 0; end
        end
      end
      if (mr == 0) begin
        if (mfull[0] || mfull[1]) begin
          if (mfull[0] && mfull[1]) mrb = 1 - mrb;
          else mrb = mfull[1] ? 1 : 0;
          m_frames = (m_frames + 1) & 16'hFFFF;
          mr = 1; mri = 0;
        end
      end else if (mr == 1) begin
        if (rd_ce) begin
          m_rd_en = 1; m_rd_addr = mrb * N + mri; m_fft = 1; mri++;
          if (mri == N) begin mr = 2; mdrain = 0; end
        end
      end else begin
        mdrain++;
        if (fft_done) rel = 1;
        else if (TMO_EN && mdrain == TMO) begin
          rel = 1; drops++; m_to = 1;
        end
        if (rel) begin mfull[mrb] = 0; m_fft = 0; mr = 0; end
      end
      if (fill) mfull[mwb] = 1;
      m_drops = (m_drops + drops > 255) ? 255 : m_drops + drops;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_on) begin
      check("wr_en", int'(wr_en), int'(m_wr_en));
      if (m_wr_en) check("wr_addr", int'(wr_addr), m_wr_addr);
      check("rd_en", int'(rd_en), int'(m_rd_en));
      if (m_rd_en) check("rd_addr", int'(rd_addr), m_rd_addr);
      check("fft_en", int'(fft_en), int'(m_fft));
      check("frame_ctr", int'(frame_ctr), m_frames);
      check("drop_ctr", int'(drop_ctr), m_drops);
      check("timeout", int'(timeout), int'(m_to));
    end
  end

  // Observed write/read traffic for literal checks
  int n_wr = 0, f_wr = -1, l_wr = -1;
  int n_rd = 0, f_rd = -1, l_rd = -1;

  always @(negedge clk) begin
    if (wr_en) begin
      if (n_wr == 0) f_wr = int'(wr_addr);
      l_wr = int'(wr_addr); n_wr++;
    end
    if (rd_en) begin
      if (n_rd == 0) f_rd = int'(rd_addr);
      l_rd = int'(rd_addr); n_rd++;
    end
  end

  task automatic clr_wr();
    n_wr = 0; f_wr = -1; l_wr = -1;
  endtask

  task automatic clr_rd();
    n_rd = 0; f_rd = -1; l_rd = -1;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chirp();
    chirp_start = 1'b1; cyc(1); chirp_start = 1'b0;
  endtask

  task automatic strobes(input int n);
    repeat (n) begin
      sample_en = 1'b1; cyc(1);
      sample_en = 1'b0; cyc(1);
    end
  endtask

  task automatic done_pulse();
    fft_done = 1'b1; cyc(1); fft_done = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".wr_en"}, int'(wr_en), 0);
    check({tag, ".wr_addr"}, int'(wr_addr), 0);
    check({tag, ".rd_en"}, int'(rd_en), 0);
    check({tag, ".rd_addr"}, int'(rd_addr), 0);
    check({tag, ".fft_en"}, int'(fft_en), 0);
    check({tag, ".frame"}, int'(frame_ctr), 0);
    check({tag, ".drop"}, int'(drop_ctr), 0);
    check({tag, ".timeout"}, int'(timeout), 0);
  endtask

  initial begin
    cyc(2);
    check_zero("reset");
    rst_n = 1'b1;
    chk_on = 1'b1;
    rd_ce = 1'b1;

    // Basic frame into bank 0
    clr_wr(); clr_rd();
    chirp(); strobes(S + N);
    check("basic.n_wr", n_wr, 16);
    check("basic.first_wr", f_wr, 0);
    check("basic.last_wr", l_wr, 15);

    // Second chirp while bank 0 is being read
    clr_wr();
    chirp(); strobes(S + N);
    check("pp.n_wr", n_wr, 16);
    check("pp.first_wr", f_wr, 16);
    check("pp.last_wr", l_wr, 31);
    check("basic.n_rd", n_rd, 16);
    check("basic.first_rd", f_rd, 0);
    check("basic.last_rd", l_rd, 15);
    check("basic.frame", int'(frame_ctr), 1);
    check("basic.fft_en", int'(fft_en), 1);

    // Overrun: both banks full, reader draining
    clr_wr();
    chirp();
    check("ovr.drop", int'(drop_ctr), 1);
    strobes(4);
    check("ovr.n_wr", n_wr, 0);

    // Release bank 0, reader moves to bank 1
    clr_rd();
    done_pulse(); cyc(25);
    check("pp.n_rd", n_rd, 16);
    check("pp.first_rd", f_rd, 16);
    check("pp.last_rd", l_rd, 31);
    check("pp.frame", int'(frame_ctr), 2);
    done_pulse(); cyc(3);
    check("pp.fft_off", int'(fft_en), 0);

    // Abort mid-capture at index 7
    rst_n = 1'b0; cyc(1); rst_n = 1'b1;
    clr_wr();
    chirp(); strobes(S + 7);
    check("abort.pre_n_wr", n_wr, 7);
    clr_wr();
    chirp();
    check("abort.drop", int'(drop_ctr), 1);
    strobes(S + N);
    check("abort.n_wr", n_wr, 16);
    check("abort.first_wr", f_wr, 0);
    check("abort.last_wr", l_wr, 15);

    // Final write of bank 1 coincides with release of bank 0
    cyc(18);
    clr_rd();
    chirp(); strobes(S + N - 1);
    sample_en = 1'b1; cyc(1); sample_en = 1'b0;
    fft_done = 1'b1; cyc(1); fft_done = 1'b0;
    cyc(25);
    check("sim.n_rd", n_rd, 16);
    check("sim.first_rd", f_rd, 16);
    check("sim.frame", int'(frame_ctr), 2);
    done_pulse(); cyc(3);

    // Reset at capture index 9
    chirp(); strobes(S + 9);
    rst_n = 1'b0; cyc(1);
    check_zero("midrst");
    rst_n = 1'b1;
    clr_wr();
    strobes(5);
    check("midrst.n_wr", n_wr, 0);

    // Long drain without fft_done
    chirp(); strobes(S + N); cyc(130);
`ifdef FRAME_SCHED_TIMEOUT_EN
    check("tmo.timeout", int'(timeout), 1);
    check("tmo.drop", int'(drop_ctr), 1);
    check("tmo.fft_en", int'(fft_en), 0);
`else
    check("hold.timeout", int'(timeout), 0);
    check("hold.drop", int'(drop_ctr), 0);
    check("hold.fft_en", int'(fft_en), 1);
`endif
    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_sched.md
# frame_sched

Frame scheduler for the FMCW receive path. It sequences each chirp's decimated FIR samples into one half of a two-bank (ping-pong) sample RAM. It hands completed banks to the FFT reader and holds a bank until the downstream FFT/USB path reports the frame drained. It also counts frames and dropped frames. It sits between the FIR decimator output, the sample RAM ports and the FFT enable/reset, in the clk_i domain; any CDC is handled outside.

## Interface
- N, 1024: samples per frame / FFT length (power of 2).
- SETTLE, 8: FIR samples discarded after chirp start before capture.
- TIMEOUT_CYCLES, 65535: drain watchdog limit (used only with FRAME_SCHED_TIMEOUT_EN).
- AW, $clog2(N)+1: RAM address width, laid out as {bank, index}.

Ports:
- clk_i  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low; clock clk_i.
- chirp_start_i  in  1  one-cycle pulse at ramp start.
- sample_en_i  in  1  one-cycle strobe; FIR output valid.
- rd_ce_i  in  1  reader clock enable (FFT sample rate).
- fft_done_i  in  1  one-cycle pulse; the last output of the current frame has been consumed downstream.
- wr_en_o  out  1  RAM write enable.
- wr_addr_o  out  AW  RAM write address.
- rd_en_o  out  1  RAM read enable.
- rd_addr_o  out  AW  RAM read address.
- fft_en_o  out  1  FFT active-low reset release; high from the first read until drain.
- frame_ctr_o  out  16  frames handed to the reader; wraps.
- drop_ctr_o  out  8  dropped/aborted frames; saturates at 255.
- timeout_o  out  1  sticky; drain watchdog fired (tied 0 without the macro).

## Operation
- Bank state is a full[1:0] bitmask plus rd_bank, wr_bank and rd_busy.
- Writer FSM:
  - W_IDLE: on chirp_start_i, choose a bank that is neither full nor being read.
    - If both banks are unavailable: increment drop_ctr_o and stay in W_IDLE.
    - Otherwise go to W_SETTLE.
  - W_SETTLE: count SETTLE sample_en_i strobes, then go to W_CAPTURE with index 0.
  - W_CAPTURE: on each sample_en_i, write {wr_bank, index} and increment index.
    - After the write at index N-1: set full[wr_bank] and return to W_IDLE.
  - chirp_start_i while in W_SETTLE or W_CAPTURE: abort, increment drop_ctr_o, and restart W_SETTLE on the same bank with index 0.
- Reader FSM:
  - R_IDLE: if any bank is full, select it (when both are full, take the bank not most recently read). Increment frame_ctr_o and go to R_READ.
  - R_READ: on each rd_ce_i, assert rd_en_o at {rd_bank, index} and increment index.
    - After index N-1: go to R_DRAIN.
  - R_DRAIN: wait for fft_done_i, then clear full[rd_bank], clear fft_en_o and go to R_IDLE.
  - fft_done_i outside R_DRAIN is ignored.
- If a writer completion and a reader release fall in the same cycle, both take effect.
- The reader holds its bank from selection through drain. The writer never targets that bank.

## Timing
- wr_en_o and wr_addr_o are registered: they are valid the cycle after the qualifying sample_en_i. The data path delays FIR data by one register to match.
- rd_en_o and rd_addr_o are registered: they are valid the cycle after rd_ce_i.
  - fft_en_o rises in the same cycle as the first rd_en_o.
  - fft_en_o falls the cycle after fft_done_i.
- full[] is set on the cycle the final write issues. The reader can select the bank one cycle later.
- Reset values: all outputs 0, both FSMs idle, full = 00, counters 0.
- A reset mid-frame discards everything; there are no partial frames after reset.

## Configuration
- FRAME_SCHED_TIMEOUT_EN defined:
  - A counter runs in R_DRAIN.
  - When it reaches TIMEOUT_CYCLES, the bank is released as if fft_done_i had arrived, drop_ctr_o is incremented and timeout_o is set (it clears only on reset).
- Undefined: R_DRAIN waits indefinitely, timeout_o is constant 0 and there is no counter logic.

## Structure
- Package frame_sched_pkg holds:
  - the writer and reader state enums;
  - the bank-index helper constants: BANK_BIT = AW-1 and IDX_W = AW-1.
- One sub-module, frame_sched_drain_wdog (counter plus compare), instantiated only under FRAME_SCHED_TIMEOUT_EN.
- Both FSMs and the bank bookkeeping live in the top module.

## Test plan
- Basic frame (N=16, SETTLE=2): chirp, 18 strobes -> 16 writes at addresses 0..15; full=01. With rd_ce_i held high -> 16 reads at 0..15; fft_en_o high; frame_ctr_o=1.
- Ping-pong: a second chirp during R_READ of bank 0 -> writes at 16..31; after fft_done_i the reader takes bank 1.
- Overrun: both banks full and the reader draining, third chirp -> no writes; drop_ctr_o increments by 1.
- Abort: chirp mid-capture at index 7 -> drop_ctr_o=1; capture restarts at index 0 on the same bank after 2 settle strobes.
- Simultaneous events: final write and fft_done_i in the same cycle -> full transitions from 11 to the expected single bit. Separately, reset at index 9 -> all outputs 0 the next cycle.
- Timeout (macro on, TIMEOUT_CYCLES=100): no fft_done_i -> release at cycle 100 of R_DRAIN; timeout_o=1; drop_ctr_o increments.
